// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// CLA_FLAGS_EN adds the out_zero/out_neg result flags.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
`ifdef CLA_FLAGS_EN
  logic             out_zero;
  logic             out_neg;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`endif
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined two-level carry-lookahead adder/subtractor, one WIDTH/STAGES segment per stage.
// Define CLA_FLAGS_EN to add the registered out_zero/out_neg result flags.
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_cla_adder_if.slave bus
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / GROUP;

  typedef struct packed {
    logic [SEG-1:0] sum;
    logic           cout;
  } segRes_t;

  function automatic segRes_t claSeg(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                     input logic cin);
    logic [SEG-1:0]  g;
    logic [SEG-1:0]  p;
    logic [SEG-1:0]  c;
    logic [NGRP-1:0] gg;
    logic [NGRP-1:0] gp;
    logic [NGRP:0]   gc;
    logic            term;
    segRes_t         res;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < NGRP; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        term = g[j*GROUP+i];
        for (int k = i + 1; k < GROUP; k++) term &= p[j*GROUP+k];
        gg[j] |= term;
        gp[j] &= p[j*GROUP+i];
      end
    end
    // Every group carry is a flat sum of products from cin, never chained group to group
    for (int j = 0; j <= NGRP; j++) begin
      term = cin;
      for (int k = 0; k < j; k++) term &= gp[k];
      gc[j] = term;
      for (int m = 0; m < j; m++) begin
        term = gg[m];
        for (int k = m + 1; k < j; k++) term &= gp[k];
        gc[j] |= term;
      end
    end
    for (int j = 0; j < NGRP; j++) begin
      for (int i = 0; i < GROUP; i++) begin
        term = gc[j];
        for (int k = 0; k < i; k++) term &= p[j*GROUP+k];
        c[j*GROUP+i] = term;
        for (int m = 0; m < i; m++) begin
          term = g[j*GROUP+m];
          for (int k = m + 1; k < i; k++) term &= p[j*GROUP+k];
          c[j*GROUP+i] |= term;
        end
      end
    end
    res.sum  = p ^ c;
    res.cout = gc[NGRP];
    return res;
  endfunction

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_inValid;
  logic [STAGES-1:0] w_open;
  logic [WIDTH-1:0]  w_bEff;
  logic              w_cinEff;

  assign w_bEff   = bus.in_b ^ {WIDTH{bus.in_sub}};
  assign w_cinEff = bus.in_cin ^ bus.in_sub;

  // A stage can load when it is empty or its occupant leaves this cycle
  always_comb begin : flow
    logic w_nextOpen;
    w_inValid    = '0;
    w_open       = '0;
    w_inValid[0] = bus.in_valid;
    for (int s = 1; s < STAGES; s++) w_inValid[s] = r_valid[s-1];
    w_nextOpen = bus.out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      w_open[s]  = !r_valid[s] || w_nextOpen;
      w_nextOpen = w_open[s];
    end
  end

  assign bus.in_ready  = w_open[0];
  assign bus.out_valid = r_valid[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (w_open[s]) r_valid[s] <= w_inValid[s];
      end
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : stg
    localparam int HI = (s + 1) * SEG - 1;
    localparam int OW = WIDTH - s * SEG;

    logic [OW-1:0] w_opA;
    logic [OW-1:0] w_opB;
    logic          w_ci;
    logic [HI:0]   w_sumNext;
    logic [HI:0]   r_sum;
    logic          r_carry;
    segRes_t       w_res;
    logic          w_load;

    assign w_res  = claSeg(w_opA[SEG-1:0], w_opB[SEG-1:0], w_ci);
    assign w_load = w_open[s] && w_inValid[s];

    if (s == 0) begin : src
      assign w_opA     = bus.in_a;
      assign w_opB     = w_bEff;
      assign w_ci      = w_cinEff;
      assign w_sumNext = w_res.sum;
    end else begin : src
      assign w_opA     = stg[s-1].upper.r_a;
      assign w_opB     = stg[s-1].upper.r_b;
      assign w_ci      = stg[s-1].r_carry;
      assign w_sumNext = {w_res.sum, stg[s-1].r_sum};
    end

    // Data only moves with a valid op so the output stays put between results
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum   <= '0;
        r_carry <= 1'b0;
      end else if (w_load) begin
        r_sum   <= w_sumNext;
        r_carry <= w_res.cout;
      end
    end

    if (s < STAGES - 1) begin : upper
      logic [OW-SEG-1:0] r_a;
      logic [OW-SEG-1:0] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_load) begin
          r_a <= w_opA[OW-1:SEG];
          r_b <= w_opB[OW-1:SEG];
        end
      end
    end else begin : fin
      logic r_ovf;
`ifdef CLA_FLAGS_EN
      logic r_zero;
      logic r_neg;
`endif

      // Carry into the MSB is recovered as sum ^ a ^ b at that bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf  <= 1'b0;
`ifdef CLA_FLAGS_EN
          r_zero <= 1'b0;
          r_neg  <= 1'b0;
`endif
        end else if (w_load) begin
          r_ovf  <= w_res.cout ^ w_res.sum[SEG-1] ^ w_opA[SEG-1] ^ w_opB[SEG-1];
`ifdef CLA_FLAGS_EN
          r_zero <= (w_sumNext == '0);
          r_neg  <= w_sumNext[WIDTH-1];
`endif
        end
      end
    end
  end

  assign bus.out_sum  = stg[STAGES-1].r_sum;
  assign bus.out_cout = stg[STAGES-1].r_carry;
  assign bus.out_ovf  = stg[STAGES-1].fin.r_ovf;
`ifdef CLA_FLAGS_EN
  assign bus.out_zero = stg[STAGES-1].fin.r_zero;
  assign bus.out_neg  = stg[STAGES-1].fin.r_neg;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder (WIDTH=32, GROUP=4, STAGES=2).
// Build with CLA_FLAGS_EN defined to also exercise out_zero/out_neg.
module tb_pipelined_cla_adder;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;
  } res_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  res_t sbq[$];

  pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_cla_adder #(.WIDTH(WIDTH), .GROUP(4), .STAGES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain wide arithmetic with the signed-overflow rule on operand/result signs
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bb;
    res_t             r;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin ^ sub};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    r.zero = (r.sum == '0);
    r.neg  = r.sum[WIDTH-1];
    return r;
  endfunction

  task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub, input logic rdy,
                      output logic acc, output logic xfer, output logic ov, output logic ir,
                      output res_t o);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cin    = cin;
    bus.in_sub    = sub;
    bus.out_ready = rdy;
    #1;
    ir     = bus.in_ready;
    ov     = bus.out_valid;
    acc    = v && ir;
    xfer   = ov && rdy;
    o.sum  = bus.out_sum;
    o.cout = bus.out_cout;
    o.ovf  = bus.out_ovf;
`ifdef CLA_FLAGS_EN
    o.zero = bus.out_zero;
    o.neg  = bus.out_neg;
`else
    o.zero = 1'b0;
    o.neg  = 1'b0;
`endif
    if (acc) sbq.push_back(model(a, b, cin, sub));
  endtask

  // Issue one op into an empty pipe and wait for it with out_ready held high
  task automatic runOne(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input logic sub, output res_t o, output int lat, output logic got);
    logic acc, xfer, ov, ir;
    res_t tmp;
    got = 1'b0;
    lat = 0;
    acc = 1'b0;
    o   = '{default: '0};
    for (int i = 0; i < 10 && !acc; i++) step(1'b1, a, b, cin, sub, 1'b1, acc, xfer, ov, ir, tmp);
    for (int i = 0; i < 10 && acc && !got; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, xfer, ov, ir, tmp);
      acc = 1'b1;
      lat++;
      if (xfer) begin
        got = 1'b1;
        o   = tmp;
      end
    end
  endtask

  task automatic test_reset();
    logic acc, xfer, ov, ir;
    res_t o;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #23;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_during_valid got=%b exp=0", bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc, xfer, ov, ir, o);
    total++;
    if (ov !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", ov); end
    total++;
    if (o.sum !== '0) begin bad++; $display("[TB] FAIL reset_sum got=%h exp=0", o.sum); end
    total++;
    if (o.cout !== 1'b0) begin bad++; $display("[TB] FAIL reset_cout got=%b exp=0", o.cout); end
    total++;
    if (o.ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b exp=0", o.ovf); end
    total++;
    if (ir !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=1", ir); end
`ifdef CLA_FLAGS_EN
    total++;
    if (o.zero !== 1'b0 || o.neg !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags got=%b%b exp=00", o.zero, o.neg);
    end
`endif
  endtask

  task automatic test_add();
    logic [WIDTH-1:0] av[5];
    logic [WIDTH-1:0] bv[5];
    logic             cv[5];
    res_t             o, e;
    int               lat;
    logic             got;
    av = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h7FFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF};
    bv = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h9ABC_DEF0, 32'hFFFF_FFFF};
    cv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    sbq.delete();
    for (int i = 0; i < 5; i++) begin
      runOne(av[i], bv[i], cv[i], 1'b0, o, lat, got);
      total++;
      if (!got || sbq.size() == 0) begin
        bad++;
        $display("[TB] FAIL add_timeout[%0d] got=no result exp=result within 10 cycles", i);
      end else begin
        e = sbq.pop_front();
        total++;
        if (o.sum !== e.sum) begin bad++; $display("[TB] FAIL add_sum[%0d] got=%h exp=%h", i, o.sum, e.sum); end
        total++;
        if (o.cout !== e.cout) begin bad++; $display("[TB] FAIL add_cout[%0d] got=%b exp=%b", i, o.cout, e.cout); end
        total++;
        if (o.ovf !== e.ovf) begin bad++; $display("[TB] FAIL add_ovf[%0d] got=%b exp=%b", i, o.ovf, e.ovf); end
        total++;
        if (lat !== 2) begin bad++; $display("[TB] FAIL add_latency[%0d] got=%0d exp=2", i, lat); end
      end
    end
  endtask

  task automatic test_sub();
    logic [WIDTH-1:0] av[5];
    logic [WIDTH-1:0] bv[5];
    logic             cv[5];
    res_t             o, e;
    int               lat;
    logic             got;
    av = '{32'h8000_0000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 32'hA5A5_A5A5};
    bv = '{32'h0000_0001, 32'h0000_0007, 32'h0000_0005, 32'h0000_0000, 32'h5A5A_5A5A};
    cv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    sbq.delete();
    for (int i = 0; i < 5; i++) begin
      runOne(av[i], bv[i], cv[i], 1'b1, o, lat, got);
      total++;
      if (!got || sbq.size() == 0) begin
        bad++;
        $display("[TB] FAIL sub_timeout[%0d] got=no result exp=result within 10 cycles", i);
      end else begin
        e = sbq.pop_front();
        total++;
        if (o.sum !== e.sum) begin bad++; $display("[TB] FAIL sub_sum[%0d] got=%h exp=%h", i, o.sum, e.sum); end
        total++;
        if (o.cout !== e.cout) begin bad++; $display("[TB] FAIL sub_cout[%0d] got=%b exp=%b", i, o.cout, e.cout); end
        total++;
        if (o.ovf !== e.ovf) begin bad++; $display("[TB] FAIL sub_ovf[%0d] got=%b exp=%b", i, o.ovf, e.ovf); end
        total++;
        if (lat !== 2) begin bad++; $display("[TB] FAIL sub_latency[%0d] got=%0d exp=2", i, lat); end
      end
    end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] av[4];
    logic [WIDTH-1:0] bv[4];
    logic             acc, xfer, ov, ir;
    res_t             o, e;
    int               idx, outs;
    av = '{32'h0000_FFFF, 32'h1111_1111, 32'hDEAD_BEEF, 32'h8000_0000};
    bv = '{32'h0000_0001, 32'h2222_2222, 32'h0BAD_F00D, 32'h8000_0000};
    sbq.delete();
    idx = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step(idx < 4, av[idx%4], bv[idx%4], 1'b0, 1'b0, 1'b0, acc, xfer, ov, ir, o);
      if (acc) idx++;
      if (ov) begin
        total++;
        if (sbq.size() == 0 || o.sum !== sbq[0].sum) begin
          bad++;
          $display("[TB] FAIL stall_hold[%0d] got=%h exp=%h", cyc, o.sum,
                   (sbq.size() == 0) ? '0 : sbq[0].sum);
        end
      end
    end
    total++;
    if (idx !== 2) begin bad++; $display("[TB] FAIL stall_accepts got=%0d exp=2", idx); end
    total++;
    if (ir !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready got=%b exp=0", ir); end
    outs = 0;
    for (int cyc = 0; cyc < 12 && outs < 4; cyc++) begin
      step(idx < 4, av[idx%4], bv[idx%4], 1'b0, 1'b0, 1'b1, acc, xfer, ov, ir, o);
      if (acc) idx++;
      total++;
      if (!xfer) begin
        bad++;
        $display("[TB] FAIL drain_rate[%0d] got=no transfer exp=one result per cycle", cyc);
      end else if (sbq.size() == 0) begin
        bad++;
        $display("[TB] FAIL drain_spurious[%0d] got=%h exp=no result", cyc, o.sum);
      end else begin
        e = sbq.pop_front();
        outs++;
        total++;
        if (o.sum !== e.sum || o.cout !== e.cout || o.ovf !== e.ovf) begin
          bad++;
          $display("[TB] FAIL drain_result[%0d] got=%h/%b/%b exp=%h/%b/%b", cyc, o.sum, o.cout,
                   o.ovf, e.sum, e.cout, e.ovf);
        end
      end
    end
    total++;
    if (outs !== 4 || sbq.size() !== 0) begin
      bad++;
      $display("[TB] FAIL drain_count got=%0d left=%0d exp=4 left=0", outs, sbq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a, b;
    logic             cin, sub, v, rdy;
    logic             acc, xfer, ov, ir;
    res_t             o, e;
    int               issued, outs, refused;
    sbq.delete();
    issued  = 0;
    outs    = 0;
    refused = 0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 20 && outs < 10; cyc++) begin
      v = (issued < 10);
      step(v, a, b, cin, sub, 1'b1, acc, xfer, ov, ir, o);
      if (v && !acc) refused++;
      if (acc) begin
        issued++;
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end
      if (xfer) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("[TB] FAIL b2b_spurious got=%h exp=no result", o.sum);
        end else begin
          e = sbq.pop_front();
          outs++;
          if (o.sum !== e.sum || o.cout !== e.cout || o.ovf !== e.ovf) begin
            bad++;
            $display("[TB] FAIL b2b_result got=%h/%b/%b exp=%h/%b/%b", o.sum, o.cout, o.ovf,
                     e.sum, e.cout, e.ovf);
          end
        end
      end
    end
    total++;
    if (refused !== 0) begin bad++; $display("[TB] FAIL b2b_throughput got=%0d refusals exp=0", refused); end
    total++;
    if (outs !== 10) begin bad++; $display("[TB] FAIL b2b_count got=%0d exp=10", outs); end
    issued = 0;
    outs   = 0;
    for (int cyc = 0; cyc < 400 && outs < 30; cyc++) begin
      v   = (issued < 30) && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(v, a, b, cin, sub, rdy, acc, xfer, ov, ir, o);
      if (acc) begin
        issued++;
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end
      if (xfer) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("[TB] FAIL rand_spurious got=%h exp=no result", o.sum);
        end else begin
          e = sbq.pop_front();
          outs++;
          if (o.sum !== e.sum || o.cout !== e.cout || o.ovf !== e.ovf) begin
            bad++;
            $display("[TB] FAIL rand_result got=%h/%b/%b exp=%h/%b/%b", o.sum, o.cout, o.ovf,
                     e.sum, e.cout, e.ovf);
          end
        end
      end
    end
    total++;
    if (outs !== 30 || sbq.size() !== 0) begin
      bad++;
      $display("[TB] FAIL rand_count got=%0d left=%0d exp=30 left=0", outs, sbq.size());
    end
  endtask

  task automatic test_reset_flight();
    logic acc0, acc1, acc, xfer, ov, ir;
    res_t o, e;
    int   lat;
    logic got;
    sbq.delete();
    step(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b1, acc0, xfer, ov, ir, o);
    step(1'b1, 32'h0000_0030, 32'h0000_0040, 1'b0, 1'b0, 1'b1, acc1, xfer, ov, ir, o);
    @(posedge clk);
    #2;
    total++;
    if (!(acc0 && acc1) || bus.out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL flight_setup got=%b%b%b exp=111", acc0, acc1, bus.out_valid);
    end
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flight_async_valid got=%b exp=0", bus.out_valid); end
    total++;
    if (bus.out_sum !== '0) begin bad++; $display("[TB] FAIL flight_async_sum got=%h exp=0", bus.out_sum); end
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flight_in_ready got=%b exp=1", bus.in_ready); end
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, xfer, ov, ir, o);
      total++;
      if (ov !== 1'b0) begin bad++; $display("[TB] FAIL flight_stale[%0d] got=%b exp=0", cyc, ov); end
    end
    runOne(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, o, lat, got);
    total++;
    if (!got || sbq.size() == 0) begin
      bad++;
      $display("[TB] FAIL flight_next_timeout got=no result exp=result");
    end else begin
      e = sbq.pop_front();
      total++;
      if (o.sum !== e.sum || lat !== 2) begin
        bad++;
        $display("[TB] FAIL flight_next got=%h lat=%0d exp=%h lat=2", o.sum, lat, e.sum);
      end
    end
  endtask

`ifdef CLA_FLAGS_EN
  task automatic test_flags();
    logic [WIDTH-1:0] av[3];
    logic [WIDTH-1:0] bv[3];
    logic             sv[3];
    res_t             o, e;
    int               lat;
    logic             got;
    av = '{32'h0000_0005, 32'h7FFF_FFFF, 32'h0000_0003};
    bv = '{32'h0000_0005, 32'h0000_0001, 32'h0000_0004};
    sv = '{1'b1, 1'b0, 1'b0};
    sbq.delete();
    for (int i = 0; i < 3; i++) begin
      runOne(av[i], bv[i], 1'b0, sv[i], o, lat, got);
      total++;
      if (!got || sbq.size() == 0) begin
        bad++;
        $display("[TB] FAIL flags_timeout[%0d] got=no result exp=result", i);
      end else begin
        e = sbq.pop_front();
        total++;
        if (o.zero !== e.zero) begin bad++; $display("[TB] FAIL flags_zero[%0d] got=%b exp=%b", i, o.zero, e.zero); end
        total++;
        if (o.neg !== e.neg) begin bad++; $display("[TB] FAIL flags_neg[%0d] got=%b exp=%b", i, o.neg, e.neg); end
        total++;
        if (o.sum !== e.sum || o.cout !== e.cout || o.ovf !== e.ovf) begin
          bad++;
          $display("[TB] FAIL flags_result[%0d] got=%h/%b/%b exp=%h/%b/%b", i, o.sum, o.cout,
                   o.ovf, e.sum, e.cout, e.ovf);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_stall();
    test_back_to_back();
    test_reset_flight();
`ifdef CLA_FLAGS_EN
    test_flags();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined N-bit carry-lookahead adder/subtractor. It is the next generation of the team's 4-bit CLA.
- Operand is split into STAGES segments; each segment is built from GROUP-bit lookahead groups with a second-level group-carry lookahead.
- One segment is resolved per pipeline stage; the carry is registered between stages.
- valid/ready handshake on both sides; full throughput of 1 op/cycle; sits between operand-issue logic and the result bus of the datapath.

Parameters:
WIDTH, 32, operand/sum width; must be divisible by STAGES.
GROUP, 4, bits per first-level lookahead group; WIDTH/STAGES must be divisible by GROUP.
STAGES, 2, pipeline register stages, equal to latency in cycles; range 1..WIDTH/GROUP.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand bundle valid
in_ready  out  1  block accepts bundle this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  carry-in (borrow-in when in_sub=1)
in_sub  in  1  0 = A+B+cin, 1 = A-B-cin
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_sum  out  WIDTH  result
out_cout  out  1  carry-out; in sub mode 1 = no borrow
out_ovf  out  1  signed overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all stage valid bits 0, out_valid 0, out_sum 0, out_cout 0, out_ovf 0. After reset in_ready is 1.
- Reset mid-operation: all in-flight ops are discarded immediately (asynchronous). No partial result appears after release.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Operand preprocessing at accept:
  - b_eff = in_b ^ {WIDTH{in_sub}}.
  - cin_eff = in_cin ^ in_sub.
  - So sub with in_cin=0 gives A-B; with in_cin=1 gives A-B-1.
- Stage s (0..STAGES-1) computes sum bits [(s+1)*SEG-1 : s*SEG], where SEG = WIDTH/STAGES.
  - Per bit: G = a&b, P = a^b.
  - Group G/P per GROUP bits; group carries by lookahead from the stage carry-in; bit carries inside each group by lookahead.
  - No ripple across groups.
  - Stage register holds: valid, completed low sum bits, carry into the next segment, and the unconsumed upper operand bits plus MSB carry-in tracking.
- Final stage produces:
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Latency: accept in cycle t → out_valid in cycle t+STAGES when not stalled. Back-to-back accepts give one result per cycle.
- Flow control:
  - Stage k advances when stage k+1 is empty or advancing; the last stage advances on out_ready.
  - in_ready = !stage0_valid || stage0_advancing. This is combinational from out_ready through the stage chain; this path is accepted.
  - Bubbles collapse: an empty stage always accepts.
- Stall: while out_valid && !out_ready, out_sum/out_cout/out_ovf are held stable. Upstream stages fill, then in_ready drops. At most STAGES ops are in flight.
- Ordering: strict FIFO. No op is dropped or duplicated.
- Simultaneous accept and output transfer in one cycle when the pipeline is full is allowed; throughput is preserved.
- STAGES=1 degenerates to a single registered WIDTH-bit two-level CLA.

Optional Feature:
Macro CLA_FLAGS_EN.
- Defined: adds two outputs, both reset to 0 and held under stall like the other outputs:
  - out_zero (1) = (out_sum == 0).
  - out_neg (1) = out_sum[WIDTH-1].
  - Both are registered in the final stage alongside out_sum.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
1. Assert rst_n=0 then release, no inputs → out_valid=0, out_sum=0, out_cout=0, out_ovf=0, in_ready=1.
2. WIDTH=32, STAGES=2: add 0xFFFFFFFF + 0x00000001, cin=0, accepted at cycle t → at t+2 out_sum=0x00000000, out_cout=1, out_ovf=0. Add 0x0000FFFF + 0x00000001 → 0x00010000, cout=0 (carry crosses the stage boundary).
3. Sub 0x80000000 - 0x00000001, in_sub=1, in_cin=0 → out_sum=0x7FFFFFFF, out_cout=1, out_ovf=1. Sub 0x5 - 0x7 → 0xFFFFFFFE, out_cout=0, out_ovf=0.
4. Issue 4 back-to-back ops with out_ready=0 → in_ready falls after 2 accepts, out_sum held constant. Raise out_ready → results emerge in issue order, 1/cycle, none lost.
5. Pull rst_n low with 2 ops in flight and out_ready=1 → out_valid=0 immediately. After release, no stale result appears and the next op has latency 2.
6. With CLA_FLAGS_EN: sub 0x5 - 0x5 → out_sum=0, out_zero=1, out_neg=0, out_cout=1. Add 0x7FFFFFFF + 1 → out_neg=1, out_ovf=1.
